// File: rtl/connect4_board_ctrl.sv
// Connect 4 board controller: holds the 6x7 grid and executes player or random drops
// requested by the turn FSM, answering with move_valid / move_reject pulses.
module connect4_board_ctrl #(
   parameter int unsigned ROWS      = 6,
   parameter int unsigned COLS      = 7,
   parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic [1:0]               i_player,
   input  logic [2:0]               i_col_sel,
   input  logic                     i_drop,
   input  logic                     i_random_move,
   input  logic                     i_clear,
   output logic                     o_move_valid,
   output logic                     o_move_reject,
   output logic                     o_board_full,
   output logic [2:0]               o_last_row,
   output logic [2:0]               o_last_col,
   output logic                     o_busy,
   output logic [2*ROWS*COLS-1:0]   o_board
);

   localparam int unsigned NBITS = 2 * ROWS * COLS;
   localparam int unsigned IDX_W = $clog2(NBITS);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_CHECK    = 3'd1;
   localparam logic [2:0] S_RAND     = 3'd2;
   localparam logic [2:0] S_WRITE    = 3'd3;
   localparam logic [2:0] S_ACK      = 3'd4;
   localparam logic [2:0] S_WAIT_REL = 3'd5;

   localparam logic [2:0] ROWS_H   = 3'(ROWS);
   localparam logic [2:0] LAST_COL = 3'(COLS - 1);
   localparam logic [3:0] COLS_W   = 4'(COLS);

   logic [2:0]       r_state, w_state_d;
   logic [7:0]       r_lfsr;
   logic [2:0]       r_col, r_cand;
   logic [1:0]       r_player;
   logic [2:0]       r_heights [8];
   logic [NBITS-1:0] r_board;
   logic [2:0]       r_last_row, r_last_col;
   logic             r_move_reject;

   logic             w_board_full, w_col_ok, w_cand_ok, w_req_ok;
   logic [2:0]       w_cand_init, w_cand_next;
   logic [IDX_W-1:0] w_wr_idx;
   logic             w_lfsr_fb;

   always_comb begin
      w_board_full = 1'b1;
      for (int c = 0; c < COLS; c++) begin
         if (r_heights[c] != ROWS_H) w_board_full = 1'b0;
      end
   end

   assign w_req_ok    = (i_player != 2'b00) && !w_board_full;
   assign w_col_ok    = ({1'b0, r_col} < COLS_W) && (r_heights[r_col] < ROWS_H);
   assign w_cand_ok   = r_heights[r_cand] < ROWS_H;
   assign w_cand_init = 3'(32'(r_lfsr[2:0]) % COLS);
   assign w_cand_next = (r_cand == LAST_COL) ? 3'd0 : r_cand + 3'd1;
   assign w_wr_idx    = IDX_W'(2 * (32'(r_heights[r_col]) * COLS + 32'(r_col)));
   // x^8 + x^6 + x^5 + x^4 + 1
   assign w_lfsr_fb   = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

   always_comb begin
      w_state_d = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_req_ok && i_drop)             w_state_d = S_CHECK;
            else if (w_req_ok && i_random_move) w_state_d = S_RAND;
         end
         S_CHECK:    w_state_d = w_col_ok ? S_WRITE : S_IDLE;
         S_RAND:     if (w_cand_ok) w_state_d = S_WRITE;
         S_WRITE:    w_state_d = S_ACK;
         S_ACK:      w_state_d = S_WAIT_REL;
         S_WAIT_REL: if (i_player == 2'b00) w_state_d = S_IDLE;
         default:    w_state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_state       <= S_IDLE;
         r_lfsr        <= LFSR_SEED;
         r_col         <= 3'd0;
         r_cand        <= 3'd0;
         r_player      <= 2'b00;
         r_board       <= '0;
         r_last_row    <= 3'd0;
         r_last_col    <= 3'd0;
         r_move_reject <= 1'b0;
         for (int c = 0; c < 8; c++) r_heights[c] <= 3'd0;
      end else begin
         r_lfsr        <= {r_lfsr[6:0], w_lfsr_fb};
         r_move_reject <= 1'b0;
         if (i_clear) begin
            // Abandons any in-flight move silently
            r_state    <= S_IDLE;
            r_board    <= '0;
            r_last_row <= 3'd0;
            r_last_col <= 3'd0;
            for (int c = 0; c < 8; c++) r_heights[c] <= 3'd0;
         end else begin
            r_state <= w_state_d;
            case (r_state)
               S_IDLE: begin
                  if (w_req_ok) begin
                     r_player <= i_player;
                     r_col    <= i_col_sel;
                     r_cand   <= w_cand_init;
                  end
               end
               S_CHECK: if (!w_col_ok) r_move_reject <= 1'b1;
               S_RAND: begin
                  if (w_cand_ok) r_col  <= r_cand;
                  else           r_cand <= w_cand_next;
               end
               S_WRITE: begin
                  r_board[w_wr_idx +: 2] <= r_player;
                  r_last_row             <= r_heights[r_col];
                  r_last_col             <= r_col;
                  r_heights[r_col]       <= r_heights[r_col] + 3'd1;
               end
               default: ;
            endcase
         end
      end
   end

   assign o_move_valid  = (r_state == S_ACK);
   assign o_move_reject = r_move_reject;
   assign o_board_full  = w_board_full;
   assign o_last_row    = r_last_row;
   assign o_last_col    = r_last_col;
   assign o_busy        = (r_state != S_IDLE);
   assign o_board       = r_board;

endmodule

// File: tb/tb_connect4_board_ctrl.sv
// Self-checking bench for connect4_board_ctrl against a grid/height model of the game rules.
module tb_connect4_board_ctrl;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic [1:0]  i_player;
   logic [2:0]  i_col_sel;
   logic        i_drop, i_random_move, i_clear;
   logic        o_move_valid, o_move_reject, o_board_full, o_busy;
   logic [2:0]  o_last_row, o_last_col;
   logic [83:0] o_board;

   int checks   = 0;
   int failures = 0;

   logic [1:0] mb [6][7];
   int         mh [7];

   connect4_board_ctrl dut (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
      .i_player      (i_player),
      .i_col_sel     (i_col_sel),
      .i_drop        (i_drop),
      .i_random_move (i_random_move),
      .i_clear       (i_clear),
      .o_move_valid  (o_move_valid),
      .o_move_reject (o_move_reject),
      .o_board_full  (o_board_full),
      .o_last_row    (o_last_row),
      .o_last_col    (o_last_col),
      .o_busy        (o_busy),
      .o_board       (o_board)
   );

   always #5 i_clk = ~i_clk;

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic model_clear();
      for (int r = 0; r < 6; r++)
         for (int c = 0; c < 7; c++) mb[r][c] = 2'b00;
      for (int c = 0; c < 7; c++) mh[c] = 0;
   endtask

   function automatic logic [83:0] exp_board();
      logic [83:0] v;
      v = '0;
      for (int r = 0; r < 6; r++)
         for (int c = 0; c < 7; c++) v[2*(r*7+c) +: 2] = mb[r][c];
      return v;
   endfunction

   function automatic logic model_full();
      for (int c = 0; c < 7; c++) if (mh[c] < 6) return 1'b0;
      return 1'b1;
   endfunction

   task automatic do_reset();
      i_rst = 1'b0; i_player = 2'b00; i_col_sel = 3'd0;
      i_drop = 1'b0; i_random_move = 1'b0; i_clear = 1'b0;
      tick(); tick();
      i_rst = 1'b1;
      model_clear();
   endtask

   // mode: 0 = drop, 1 = random_move, 2 = both in the same cycle
   task automatic run_move(input logic [1:0] p, input logic [2:0] c, input int mode,
                           output logic got_v, output logic got_r, output int lat,
                           output int extra, output logic busy_all, output logic any_busy,
                           output logic [2:0] lr, output logic [2:0] lc,
                           output logic full_ack);
      got_v = 1'b0; got_r = 1'b0; lat = -1; extra = 0; busy_all = 1'b1; any_busy = 1'b0;
      lr = 3'd0; lc = 3'd0; full_ack = 1'b0;
      i_player = p; i_col_sel = c;
      i_drop = (mode != 1); i_random_move = (mode != 0);
      for (int k = 1; k <= 15; k++) begin
         tick();
         i_drop = 1'b0;
         busy_all = busy_all & o_busy;
         any_busy = any_busy | o_busy;
         if (o_move_valid) begin
            got_v = 1'b1; lat = k; lr = o_last_row; lc = o_last_col; full_ack = o_board_full;
            break;
         end
         if (o_move_reject) begin
            got_r = 1'b1; lat = k;
            break;
         end
      end
      for (int k = 0; k < 4; k++) begin
         tick();
         if (o_move_valid || o_move_reject) extra++;
         any_busy = any_busy | o_busy;
         if (got_v) busy_all = busy_all & o_busy;
      end
      i_player = 2'b00; i_random_move = 1'b0;
      tick(); tick();
   endtask

   logic       v, rj, ba, ab, fa;
   logic [2:0] lr, lc;
   int         lat, ex;

   task automatic test_reset();
      do_reset();
      checks++;
      if (o_board !== 84'd0) begin
         failures++; $display("FAIL reset_board got=%h exp=0", o_board);
      end
      checks++;
      if ({o_move_valid, o_move_reject, o_board_full, o_busy, o_last_row, o_last_col} !== 10'd0) begin
         failures++;
         $display("FAIL reset_outputs got=%b exp=0",
                  {o_move_valid, o_move_reject, o_board_full, o_busy, o_last_row, o_last_col});
      end
   endtask

   task automatic test_drop_basic();
      run_move(2'b01, 3'd3, 0, v, rj, lat, ex, ba, ab, lr, lc, fa);
      mb[0][3] = 2'b01; mh[3] = 1;
      checks++;
      if (!(v === 1'b1 && lat == 3 && ex == 0)) begin
         failures++; $display("FAIL basic_latency got=v%0b lat=%0d extra=%0d exp=v1 lat=3 extra=0", v, lat, ex);
      end
      checks++;
      if ({lr, lc} !== {3'd0, 3'd3}) begin
         failures++; $display("FAIL basic_last got=%0d,%0d exp=0,3", lr, lc);
      end
      checks++;
      if (o_board !== exp_board()) begin
         failures++; $display("FAIL basic_board got=%h exp=%h", o_board, exp_board());
      end
      checks++;
      if (!(ba === 1'b1 && o_busy === 1'b0)) begin
         failures++; $display("FAIL basic_busy got=held%0b after%0b exp=held1 after0", ba, o_busy);
      end
   endtask

   task automatic test_full_column();
      do_reset();
      for (int i = 0; i < 6; i++) begin
         logic [1:0] p;
         p = (i % 2 == 0) ? 2'b01 : 2'b10;
         run_move(p, 3'd0, 0, v, rj, lat, ex, ba, ab, lr, lc, fa);
         mb[i][0] = p; mh[0]++;
         checks++;
         if (!(v === 1'b1 && lr == 3'(i) && lc == 3'd0)) begin
            failures++; $display("FAIL col0_fill%0d got=v%0b row%0d col%0d exp=v1 row%0d col0", i, v, lr, lc, i);
         end
      end
      run_move(2'b01, 3'd0, 0, v, rj, lat, ex, ba, ab, lr, lc, fa);
      checks++;
      if (!(rj === 1'b1 && v === 1'b0 && lat == 2 && ex == 0)) begin
         failures++; $display("FAIL col0_reject got=r%0b v%0b lat=%0d exp=r1 v0 lat=2", rj, v, lat);
      end
      checks++;
      if (o_board !== exp_board()) begin
         failures++; $display("FAIL col0_board got=%h exp=%h", o_board, exp_board());
      end
   endtask

   task automatic test_random_drop();
      do_reset();
      for (int c = 0; c < 6; c++)
         for (int r = 0; r < 6; r++) begin
            logic [1:0] p;
            p = ((r + c) % 2 == 0) ? 2'b01 : 2'b10;
            run_move(p, 3'(c), 0, v, rj, lat, ex, ba, ab, lr, lc, fa);
            mb[r][c] = p; mh[c]++;
         end
      checks++;
      if (o_board !== exp_board()) begin
         failures++; $display("FAIL rand_prefill_board got=%h exp=%h", o_board, exp_board());
      end
      run_move(2'b10, 3'd0, 1, v, rj, lat, ex, ba, ab, lr, lc, fa);
      mb[0][6] = 2'b10; mh[6] = 1;
      checks++;
      if (!(v === 1'b1 && lr == 3'd0 && lc == 3'd6 && lat >= 3 && lat <= 9)) begin
         failures++; $display("FAIL rand_col6 got=v%0b row%0d col%0d lat=%0d exp=v1 row0 col6", v, lr, lc, lat);
      end
      checks++;
      if (ex != 0) begin
         failures++; $display("FAIL rand_single got=%0d extra pulses exp=0", ex);
      end
      checks++;
      if (o_board !== exp_board()) begin
         failures++; $display("FAIL rand_board got=%h exp=%h", o_board, exp_board());
      end
   endtask

   task automatic test_board_full();
      for (int r = 1; r < 6; r++) begin
         logic [1:0] p;
         p = (r % 2 == 0) ? 2'b01 : 2'b10;
         run_move(p, 3'd6, 0, v, rj, lat, ex, ba, ab, lr, lc, fa);
         mb[r][6] = p; mh[6]++;
         checks++;
         if (!(v === 1'b1 && fa === model_full())) begin
            failures++; $display("FAIL full_ack%0d got=v%0b full%0b exp=v1 full%0b", r, v, fa, model_full());
         end
      end
      checks++;
      if (o_board !== exp_board() || o_board_full !== 1'b1) begin
         failures++; $display("FAIL full_board got=%h full%0b exp=%h full1", o_board, o_board_full, exp_board());
      end
      for (int m = 0; m < 2; m++) begin
         run_move(2'b01, 3'd2, m, v, rj, lat, ex, ba, ab, lr, lc, fa);
         checks++;
         if (!(v === 1'b0 && rj === 1'b0 && ab === 1'b0 && ex == 0)) begin
            failures++; $display("FAIL full_ignore%0d got=v%0b r%0b busy%0b exp=v0 r0 busy0", m, v, rj, ab);
         end
      end
   endtask

   task automatic test_priority();
      do_reset();
      run_move(2'b01, 3'd2, 2, v, rj, lat, ex, ba, ab, lr, lc, fa);
      mb[0][2] = 2'b01; mh[2] = 1;
      checks++;
      if (!(v === 1'b1 && lr == 3'd0 && lc == 3'd2 && lat == 3 && ex == 0)) begin
         failures++; $display("FAIL prio_drop got=v%0b row%0d col%0d lat=%0d exp=v1 row0 col2 lat3", v, lr, lc, lat);
      end
      run_move(2'b10, 3'd7, 0, v, rj, lat, ex, ba, ab, lr, lc, fa);
      checks++;
      if (!(rj === 1'b1 && v === 1'b0 && o_board === exp_board())) begin
         failures++; $display("FAIL col7_reject got=r%0b v%0b board=%h exp=r1 v0 board=%h", rj, v, o_board, exp_board());
      end
   endtask

   task automatic test_clear_reset();
      int seen;
      logic [2:0] col_a;
      do_reset();
      run_move(2'b01, 3'd5, 0, v, rj, lat, ex, ba, ab, lr, lc, fa);
      i_player = 2'b10; i_col_sel = 3'd4; i_drop = 1'b1;
      tick(); i_drop = 1'b0;
      tick();
      i_clear = 1'b1;
      tick();
      i_clear = 1'b0; i_player = 2'b00;
      seen = 0;
      for (int k = 0; k < 4; k++) begin
         tick();
         if (o_move_valid || o_move_reject) seen++;
      end
      model_clear();
      checks++;
      if (!(seen == 0 && o_board === 84'd0 && o_busy === 1'b0 && {o_last_row, o_last_col} === 6'd0)) begin
         failures++; $display("FAIL clear_write got=pulses%0d board=%h busy%0b exp=0 0 0", seen, o_board, o_busy);
      end
      run_move(2'b10, 3'd5, 0, v, rj, lat, ex, ba, ab, lr, lc, fa);
      i_player = 2'b01; i_col_sel = 3'd1; i_drop = 1'b1;
      tick(); i_drop = 1'b0;
      i_rst = 1'b0;
      tick();
      checks++;
      if ({o_move_valid, o_move_reject, o_board_full, o_busy, o_last_row, o_last_col} !== 10'd0
          || o_board !== 84'd0) begin
         failures++; $display("FAIL reset_check got=%b board=%h exp=0",
                  {o_move_valid, o_move_reject, o_board_full, o_busy, o_last_row, o_last_col}, o_board);
      end
      i_rst = 1'b1; i_player = 2'b00;
      // Same cycle offset after reset must yield the same random column
      do_reset();
      repeat (5) tick();
      run_move(2'b01, 3'd0, 1, v, rj, lat, ex, ba, ab, lr, lc, fa);
      col_a = lc;
      checks++;
      if (!(v === 1'b1 && lr == 3'd0 && lc < 3'd7 && lat == 3)) begin
         failures++; $display("FAIL lfsr_first got=v%0b row%0d col%0d lat=%0d exp=v1 row0 lat3", v, lr, lc, lat);
      end
      do_reset();
      repeat (5) tick();
      run_move(2'b01, 3'd0, 1, v, rj, lat, ex, ba, ab, lr, lc, fa);
      checks++;
      if (!(v === 1'b1 && lc == col_a)) begin
         failures++; $display("FAIL lfsr_reload got=col%0d exp=col%0d", lc, col_a);
      end
   endtask

   task automatic test_random_play();
      do_reset();
      for (int i = 0; i < 70; i++) begin
         logic [1:0] p;
         logic [2:0] c;
         int mode, ec;
         logic pre_full;
         p = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
         c = 3'($urandom_range(0, 7));
         mode = ($urandom_range(0, 3) == 0) ? 1 : 0;
         pre_full = model_full();
         run_move(p, c, mode, v, rj, lat, ex, ba, ab, lr, lc, fa);
         checks++;
         if (pre_full) begin
            if (v !== 1'b0 || rj !== 1'b0 || ab !== 1'b0) begin
               failures++; $display("FAIL play%0d_full got=v%0b r%0b busy%0b exp=0 0 0", i, v, rj, ab);
            end
         end else if (mode == 0 && (c > 3'd6 || mh[c] >= 6)) begin
            if (!(rj === 1'b1 && v === 1'b0 && lat == 2)) begin
               failures++; $display("FAIL play%0d_reject got=r%0b v%0b lat=%0d exp=r1 v0 lat2", i, rj, v, lat);
            end
         end else begin
            ec = (mode == 0) ? int'(c) : int'(lc);
            if (!(v === 1'b1 && ex == 0 && ec < 7 && int'(lc) == ec && mh[ec] < 6 &&
                  int'(lr) == mh[ec] && (mode == 1 ? (lat >= 3 && lat <= 9) : lat == 3))) begin
               failures++;
               $display("FAIL play%0d_move got=v%0b row%0d col%0d lat=%0d exp=v1 col%0d mode%0d",
                        i, v, lr, lc, lat, ec, mode);
            end else begin
               mb[mh[ec]][ec] = p; mh[ec]++;
            end
         end
         checks++;
         if (o_board !== exp_board() || o_board_full !== model_full()) begin
            failures++; $display("FAIL play%0d_state got=%h full%0b exp=%h full%0b",
                                 i, o_board, o_board_full, exp_board(), model_full());
         end
      end
   endtask

   initial begin
      test_reset();
      test_drop_basic();
      test_full_column();
      test_random_drop();
      test_board_full();
      test_priority();
      test_clear_reset();
      test_random_play();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
